// File: rtl/osiris_apb_pkg.sv
// Shared types and helpers for the multi-requester APB master.
package osiris_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_mst_state_e;

    localparam int APB_TIMEOUT_DEFAULT = 16;

    // Index reached by stepping 'off' positions from 'base' on a ring of 'n' requesters.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer.
module apb_rr_arbiter
    import osiris_apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign w_cand[gi] = IDX_W'(rr_wrap(32'(i_ptr), gi, NUM_REQ));
    end

    // Scan from the farthest candidate back so the closest valid one wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_valid[w_cand[k]]) begin
                o_grant_idx = w_cand[k];
                o_any       = 1'b1;
            end
        end
        o_grant[o_grant_idx] = o_any;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin multi-requester APB master with per-transfer ACCESS timeout.
module apb_master_arbiter
    import osiris_apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                          pclk,
    input  logic                          i_preset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    output logic                          o_rsp_err,
    output logic                          o_psel,
    output logic                          o_penable,
    output logic                          o_pwrite,
    output logic [ADDR_WIDTH-1:0]         o_paddr,
    output logic [DATA_WIDTH-1:0]         o_pwdata,
    input  logic [DATA_WIDTH-1:0]         i_prdata,
    input  logic                          i_pready,
    input  logic                          i_pslverr
);

    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_mst_state_e         r_state, w_state_next;
    logic [IDX_W-1:0]       r_ptr, r_gnt_idx;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_write;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err;

    logic [NUM_REQ-1:0]     w_gnt_onehot;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_any;
    logic                   w_accept, w_capture, w_timeout, w_cnt_inc, w_bus_active;

    logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = i_req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign o_rsp_valid[gi] = (r_state == ST_RESP) && (r_gnt_idx == IDX_W'(gi));
    end

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_valid     (i_req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_gnt_onehot),
        .o_grant_idx (w_gnt_idx),
        .o_any       (w_gnt_any)
    );

    always_ff @(posedge pclk or negedge i_preset_n) begin
        if (!i_preset_n) r_state <= ST_IDLE;
        else             r_state <= w_state_next;
    end

    // Accept is masked while reset is held so no requester sees a lost handshake.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any && i_preset_n) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP:  w_state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (i_pready) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge i_preset_n) begin
        if (!i_preset_n) begin
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt_idx <= w_gnt_idx;
                r_addr    <= w_addr_arr[w_gnt_idx];
                r_wdata   <= w_wdata_arr[w_gnt_idx];
                r_write   <= i_req_write[w_gnt_idx];
            end
            if (r_state == ST_SETUP)  r_cnt <= '0;
            else if (w_cnt_inc)       r_cnt <= r_cnt + 1'b1;
            if (w_capture) begin
                r_rdata <= i_prdata;
                r_err   <= i_pslverr;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
            if (r_state == ST_RESP)
                r_ptr <= IDX_W'(rr_wrap(32'(r_gnt_idx), 1, NUM_REQ));
        end
    end

    assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign o_psel       = w_bus_active;
    assign o_penable    = (r_state == ST_ACCESS);
    assign o_paddr      = w_bus_active ? r_addr  : '0;
    assign o_pwdata     = w_bus_active ? r_wdata : '0;
    assign o_pwrite     = w_bus_active && r_write;
    assign o_req_ready  = w_accept ? w_gnt_onehot : '0;
    assign o_rsp_rdata  = r_rdata;
    assign o_rsp_err    = r_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: vector table, reset-abort sequence and randomized traffic vs a ring model.
module tb_apb_master_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              i_preset_n;
    logic [NR-1:0]     i_req_valid, i_req_write;
    logic [NR*AW-1:0]  i_req_addr;
    logic [NR*DW-1:0]  i_req_wdata;
    logic [NR-1:0]     o_req_ready, o_rsp_valid;
    logic [DW-1:0]     o_rsp_rdata;
    logic              o_rsp_err, o_psel, o_penable, o_pwrite;
    logic [AW-1:0]     o_paddr;
    logic [DW-1:0]     o_pwdata;
    logic [DW-1:0]     i_prdata;
    logic              i_pready, i_pslverr;

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .i_preset_n(i_preset_n),
        .i_req_valid(i_req_valid), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pwdata(o_pwdata),
        .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;
    int xfer_no = 0;

    logic [AW-1:0] tb_addr  [NR];
    logic [DW-1:0] tb_wdata [NR];
    logic          tb_write [NR];

    // Slave: answers after slave_waits ACCESS cycles (negative = never); junk while not ready.
    int            slave_waits = 0;
    logic [DW-1:0] slave_rdata = '0;
    logic          slave_err = 1'b0;
    int            acc_cnt = 0;

    always @(negedge pclk) begin
        if (o_psel && o_penable) begin
            if (slave_waits >= 0 && acc_cnt == slave_waits) begin
                i_pready  = 1'b1;
                i_prdata  = slave_rdata;
                i_pslverr = slave_err;
            end else begin
                i_pready  = 1'b0;
                i_prdata  = $urandom;
                i_pslverr = 1'($urandom_range(0, 1));
            end
            acc_cnt++;
        end else begin
            i_pready  = 1'b0;
            i_prdata  = '0;
            i_pslverr = 1'b0;
            acc_cnt   = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requesting index walking the ring from the pointer.
    function automatic int model_pick(input logic [NR-1:0] m, input int ptr);
        for (int k = 0; k < NR; k++)
            if (m[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic drive_reqs(input logic [NR-1:0] mask);
        for (int r = 0; r < NR; r++) begin
            i_req_addr[r*AW +: AW]  = tb_addr[r];
            i_req_wdata[r*DW +: DW] = tb_wdata[r];
            i_req_write[r]          = tb_write[r];
        end
        i_req_valid = mask;
    endtask

    task automatic run_xfer(input logic [NR-1:0] mask, input int exp_g, input int waits,
                            input logic [DW-1:0] prdata, input logic perr,
                            input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat,
                            input string tag);
        int lat, acc, first_sel, first_en;
        bit got, bus_ok, seen_rsp, ready_quiet;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic          ewr;
        ea = tb_addr[exp_g]; ew = tb_wdata[exp_g]; ewr = tb_write[exp_g];
        @(posedge pclk); #1;
        slave_waits = waits; slave_rdata = prdata; slave_err = perr;
        drive_reqs(mask);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge pclk);
            if (o_req_ready != '0) got = 1;
        end
        check({tag, ".accept_seen"}, 64'(got), 64'(1));
        if (!got) begin
            i_req_valid = '0;
            return;
        end
        check({tag, ".req_ready"}, 64'(o_req_ready), 64'(NR'(1) << exp_g));
        @(posedge pclk); #1;
        i_req_valid = '0;
        for (int r = 0; r < NR; r++) begin
            i_req_addr[r*AW +: AW]  = $urandom;
            i_req_wdata[r*DW +: DW] = $urandom;
        end
        lat = 0; acc = 0; first_sel = -1; first_en = -1;
        bus_ok = 1; seen_rsp = 0; ready_quiet = 1;
        while (!seen_rsp && lat < 40) begin
            @(negedge pclk); lat++;
            if (o_req_ready != '0) ready_quiet = 0;
            if (o_psel) begin
                if (first_sel < 0) first_sel = lat;
                if (o_penable) begin
                    acc++;
                    if (first_en < 0) first_en = lat;
                end
                if (o_paddr !== ea || o_pwdata !== ew || o_pwrite !== ewr) bus_ok = 0;
            end else if (o_penable || o_paddr !== '0 || o_pwdata !== '0 || o_pwrite !== 1'b0) begin
                bus_ok = 0;
            end
            if (o_rsp_valid != '0) seen_rsp = 1;
        end
        check({tag, ".rsp_seen"},     64'(seen_rsp),    64'(1));
        check({tag, ".rsp_latency"},  64'(lat),         64'(exp_lat));
        check({tag, ".setup_cycle"},  64'(first_sel),   64'(1));
        check({tag, ".access_cycle"}, 64'(first_en),    64'(2));
        check({tag, ".access_count"}, 64'(acc),         64'(exp_lat - 2));
        check({tag, ".bus_hold"},     64'(bus_ok),      64'(1));
        check({tag, ".ready_quiet"},  64'(ready_quiet), 64'(1));
        check({tag, ".rsp_valid"},    64'(o_rsp_valid), 64'(NR'(1) << exp_g));
        check({tag, ".rsp_rdata"},    64'(o_rsp_rdata), 64'(exp_rd));
        check({tag, ".rsp_err"},      64'(o_rsp_err),   64'(exp_err));
        @(negedge pclk);
        check({tag, ".rsp_pulse_end"}, 64'(o_rsp_valid), 64'(0));
        check({tag, ".rdata_hold"},    64'(o_rsp_rdata), 64'(exp_rd));
        check({tag, ".err_hold"},      64'(o_rsp_err),   64'(exp_err));
        model_ptr = (exp_g + 1) % NR;
        $display("xfer %0d %s: mask=%b grant=%0d wr=%0d addr=%h waits=%0d lat=%0d rdata=%h err=%0d",
                 xfer_no, tag, mask, exp_g, ewr, ea, waits, lat, o_rsp_rdata, o_rsp_err);
        xfer_no++;
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          perr;
        int            exp_g;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic load_payload(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic wr, input int g);
        for (int r = 0; r < NR; r++) begin
            tb_addr[r]  = (r == g) ? addr  : addr + AW'(32'h100 * (r + 1));
            tb_wdata[r] = (r == g) ? wdata : wdata + DW'(r + 1);
            tb_write[r] = (r == g) ? wr    : ~wr;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got, rsp_bad;
        int g, waits, pick;
        logic [NR-1:0] mask;
        logic [DW-1:0] prd;
        logic perr;

        //            mask    wr    addr          wdata         waits prdata        perr  g  exp_rdata     err  lat
        vecs[0] = '{3'b001, 1'b0, 32'h0000A000, 32'h00000000,  0, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{3'b010, 1'b1, 32'h0000A004, 32'h12345678,  3, 32'h5555AAAA, 1'b0, 1, 32'h5555AAAA, 1'b0, 6};
        vecs[2] = '{3'b001, 1'b0, 32'h0000A008, 32'h00000000,  0, 32'h0BAD0BAD, 1'b1, 0, 32'h0BAD0BAD, 1'b1, 3};
        vecs[3] = '{3'b100, 1'b0, 32'h0000A00C, 32'h00000000, -1, 32'hFFFFFFFF, 1'b0, 2, 32'h00000000, 1'b1, 18};
        vecs[4] = '{3'b011, 1'b0, 32'h0000A010, 32'h00000000,  0, 32'h11111111, 1'b0, 0, 32'h11111111, 1'b0, 3};
        vecs[5] = '{3'b011, 1'b1, 32'h0000A014, 32'hCAFE0005,  1, 32'h22222222, 1'b0, 1, 32'h22222222, 1'b0, 4};
        vecs[6] = '{3'b011, 1'b0, 32'h0000A018, 32'h00000000,  0, 32'h33333333, 1'b0, 0, 32'h33333333, 1'b0, 3};
        vecs[7] = '{3'b011, 1'b1, 32'h0000A01C, 32'hCAFE0007,  2, 32'h44444444, 1'b0, 1, 32'h44444444, 1'b0, 5};
        vecs[8] = '{3'b111, 1'b0, 32'h0000A020, 32'h00000000,  0, 32'h55555555, 1'b0, 2, 32'h55555555, 1'b0, 3};
        vecs[9] = '{3'b110, 1'b0, 32'h0000A024, 32'h00000000,  0, 32'h66666666, 1'b1, 1, 32'h66666666, 1'b1, 3};

        i_preset_n  = 1'b0;
        i_req_valid = '0;
        i_req_write = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        repeat (2) @(negedge pclk);
        check("reset.psel",      64'(o_psel),      64'(0));
        check("reset.penable",   64'(o_penable),   64'(0));
        check("reset.paddr",     64'(o_paddr),     64'(0));
        check("reset.pwdata",    64'(o_pwdata),    64'(0));
        check("reset.pwrite",    64'(o_pwrite),    64'(0));
        check("reset.req_ready", 64'(o_req_ready), 64'(0));
        check("reset.rsp_valid", 64'(o_rsp_valid), 64'(0));
        check("reset.rsp_rdata", 64'(o_rsp_rdata), 64'(0));
        check("reset.rsp_err",   64'(o_rsp_err),   64'(0));
        @(posedge pclk); #1;
        i_preset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            load_payload(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].exp_g);
            run_xfer(vecs[i].mask, vecs[i].exp_g, vecs[i].waits, vecs[i].prdata, vecs[i].perr,
                     vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset during ACCESS: bus drops at once, no response, pointer back to 0.
        load_payload(32'h0000C000, 32'h0, 1'b0, 0);
        @(posedge pclk); #1;
        slave_waits = -1;
        drive_reqs(3'b001);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge pclk);
            if (o_req_ready != '0) got = 1;
        end
        check("rst_mid.accept", 64'(o_req_ready), 64'(3'b001));
        @(posedge pclk); #1;
        i_req_valid = '0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge pclk);
            if (o_psel && o_penable) got = 1;
        end
        check("rst_mid.in_access", 64'(got), 64'(1));
        repeat (3) @(negedge pclk);
        #2;
        i_preset_n = 1'b0;
        #1;
        check("rst_mid.psel_low",    64'(o_psel),    64'(0));
        check("rst_mid.penable_low", 64'(o_penable), 64'(0));
        rsp_bad = 0;
        repeat (2) begin
            @(negedge pclk);
            if (o_rsp_valid != '0) rsp_bad = 1;
        end
        check("rst_mid.rsp_rdata_clr", 64'(o_rsp_rdata), 64'(0));
        @(posedge pclk); #1;
        i_preset_n = 1'b1;
        model_ptr  = 0;
        repeat (3) begin
            @(negedge pclk);
            if (o_rsp_valid != '0 || o_psel) rsp_bad = 1;
        end
        check("rst_mid.no_rsp", 64'(rsp_bad), 64'(0));
        load_payload(32'h0000C104, 32'h0, 1'b0, 1);
        run_xfer(3'b110, 1, 0, 32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 1'b0, 3, "post_rst");

        // Randomized traffic against the ring model.
        for (int i = 0; i < 40; i++) begin
            mask  = NR'($urandom_range(1, (1 << NR) - 1));
            pick  = $urandom_range(0, 7);
            waits = (pick == 7) ? -1 : pick % 4;
            prd   = $urandom;
            perr  = ($urandom_range(0, 3) == 0);
            for (int r = 0; r < NR; r++) begin
                tb_addr[r]  = $urandom;
                tb_wdata[r] = $urandom;
                tb_write[r] = 1'($urandom_range(0, 1));
            end
            g = model_pick(mask, model_ptr);
            if (waits < 0)
                run_xfer(mask, g, waits, prd, perr, '0, 1'b1, TO + 2, $sformatf("rnd%0d", i));
            else
                run_xfer(mask, g, waits, prd, perr, prd, perr, waits + 3, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Multi-requester APB master: accepts transfer requests from NUM_REQ on-chip requesters (e.g. core LSU, debug module) and arbitrates them round-robin.
- Sequences each granted request through the APB IDLE/SETUP/ACCESS protocol on a single shared APB port.
- Returns read data and error status to the granted requester; a per-transfer timeout guards against a slave that never asserts i_pready.
- Sits between the core-side request fabric and the APB peripheral decoder.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock.
- i_preset_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_write  in  NUM_REQ  per-requester write (1) / read (0).
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester r at [r*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- o_req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- o_rsp_rdata  out  DATA_WIDTH  read data, valid with o_rsp_valid.
- o_rsp_err  out  1  slave error or timeout, valid with o_rsp_valid.
- o_psel  out  1  APB select.
- o_penable  out  1  APB enable.
- o_pwrite  out  1  APB direction.
- o_paddr  out  ADDR_WIDTH  APB address.
- o_pwdata  out  DATA_WIDTH  APB write data.
- i_prdata  in  DATA_WIDTH  APB read data.
- i_pready  in  1  APB ready.
- i_pslverr  in  1  APB slave error.

Behaviour:
- Reset state:
  - state = ST_IDLE, rr pointer = 0, timeout counter = 0.
  - All outputs 0, including the latched address, data and write regs.
- ST_IDLE:
  - If any i_req_valid is set, grant g = first valid index at or after the rr pointer (wrapping modulo NUM_REQ).
  - Pulse o_req_ready[g]; latch addr/wdata/write of g and g itself; go to ST_SETUP.
  - Otherwise stay in ST_IDLE.
- ST_SETUP: o_psel=1, o_penable=0; address, write and wdata driven from latches; counter cleared; go to ST_ACCESS.
- ST_ACCESS: o_psel=1, o_penable=1.
  - If i_pready: capture i_prdata (captured for writes too) and i_pslverr; go to ST_RESP.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: rdata=0, err=1; go to ST_RESP.
  - Else counter += 1.
- ST_RESP: o_psel=0; o_rsp_valid[g]=1 for one cycle with o_rsp_rdata and o_rsp_err; rr pointer = (g+1) mod NUM_REQ; go to ST_IDLE.
- Signal hold rules:
  - o_paddr, o_pwrite and o_pwdata equal the latched values in SETUP and ACCESS, and 0 otherwise.
  - o_rsp_rdata and o_rsp_err hold their last values outside ST_RESP.
- Latency: accept at cycle k, SETUP at k+1, ACCESS at k+2; with zero-wait i_pready, o_rsp_valid at k+3. Minimum 4 cycles per transfer; next accept no earlier than k+4.
- Requester contract: hold valid and payload stable until o_req_ready. A valid that drops before ready is a legal withdrawal; no response is generated.
- Simultaneous requests: exactly one o_req_ready bit per grant. A requester that is not granted keeps waiting and is granted within NUM_REQ transfers (starvation-free).
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Reset mid-transfer: immediate return to ST_IDLE with o_psel/o_penable low; no o_rsp_valid for the aborted transfer.

Decomposition:
- Package osiris_apb_pkg:
  - enum apb_mst_state_e {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP}, 2 bits.
  - localparam APB_TIMEOUT_DEFAULT = 16.
- One sub-module, apb_rr_arbiter: combinational round-robin priority pick from (valid vector, pointer), producing a one-hot grant and a grant index. The pointer register stays in the top module.

Test Plan:
- Single read, req0 addr=0xA000, zero-wait slave returning 0xDEADBEEF → o_req_ready[0] at k; psel at k+1; penable at k+2; o_rsp_valid[0] at k+3 with rdata=0xDEADBEEF, err=0.
- Write, req1 addr=0xA004 wdata=0x12345678, slave inserts 3 wait states → o_pwrite=1, paddr and pwdata stable for all 5 SETUP+ACCESS cycles; o_rsp_valid[1] at k+6, err=0.
- Both requesters valid continuously, 4 transfers → grant order 0,1,0,1; o_req_ready never has more than one bit set.
- i_pready held 0, TIMEOUT_CYCLES=16 → exactly 16 ACCESS cycles, then o_rsp_valid with err=1 and rdata=0; FSM returns to IDLE.
- Slave returns i_pslverr=1 with i_pready → o_rsp_err=1 delivered to the granted requester only.
- i_preset_n asserted during ACCESS → o_psel and o_penable low immediately, no o_rsp_valid; after release, a new request on req1 is granted first (rr pointer reset to 0, req0 idle).
